// File: rtl/seg_display_arbiter_pkg.sv
// Shared types, widths and the round-robin search helper for the display arbiter.
package seg_disp_pkg;

  localparam int VALUE_W = 16;
  localparam int MAX_REQ = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1
  } state_t;

  // One-hot pick of the first set req bit, searching last+1, last+2, ... modulo n.
  // The search wraps all the way round, so `last` itself is checked last.
  function automatic logic [MAX_REQ-1:0] rr_next(input logic [2:0] last,
                                                 input logic [MAX_REQ-1:0] req,
                                                 input int n);
    logic [MAX_REQ-1:0] pick;
    logic               done;
    logic [2:0]         sel;
    int                 idx;
    pick = '0;
    done = 1'b0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      if (k <= n && !done) begin
        idx = (int'(last) + k) % n;
        sel = idx[2:0];
        if (req[sel]) begin
          pick[sel] = 1'b1;
          done      = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/seg_display_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after `last`, skipping `exclude`.
module rr_pick
  import seg_disp_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [2:0]       last,
  input  logic [N_REQ-1:0] exclude,
  output logic [N_REQ-1:0] winner,
  output logic             found
);

  logic [MAX_REQ-1:0] masked;
  logic [MAX_REQ-1:0] pick;

  // Mask out the excluded requester, then run the rotating priority search.
  always_comb begin
    masked              = '0;
    masked[N_REQ-1:0]   = req & ~exclude;
    pick                = rr_next(last, masked, N_REQ);
    winner              = pick[N_REQ-1:0];
    found               = |pick;
  end

endmodule

// File: rtl/seg_display_arbiter.sv
// Round-robin owner of the 4-digit display with a minimum dwell per owner.
// The owner's value is re-registered every cycle so live updates appear one cycle later.
module seg_display_arbiter
  import seg_disp_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int DWELL_CYCLES = 200_000_000,
  parameter int CNT_W        = 28
) (
  input  logic                     clock_100Mhz,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [VALUE_W*N_REQ-1:0] req_value,
  output logic [N_REQ-1:0]         ack,
  output logic [N_REQ-1:0]         grant,
  output logic [VALUE_W-1:0]       disp_value,
  output logic                     disp_blank
);

  localparam logic [CNT_W-1:0] DWELL_MAX = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [2:0]       LAST_RST  = 3'(N_REQ - 1);

  state_t               state_reg, state_next;
  logic [N_REQ-1:0]     grant_reg, grant_next;
  logic [N_REQ-1:0]     ack_reg, ack_next;
  logic [2:0]           last_reg, last_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [VALUE_W-1:0]   value_reg, value_next;
  logic                 blank_reg, blank_next;

  logic [N_REQ-1:0]     winner;
  logic                 found;
  logic [VALUE_W-1:0]   win_value;
  logic [VALUE_W-1:0]   own_value;
  logic [2:0]           win_idx;
  logic                 owner_req;
  logic                 at_dwell;
  logic                 take;

  // The current owner never competes against itself, so a switch always moves elsewhere.
  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req     (req),
    .last    (last_reg),
    .exclude (grant_reg),
    .winner  (winner),
    .found   (found)
  );

  // Select the winner's and the owner's values from the packed request bus.
  always_comb begin
    win_value = '0;
    own_value = '0;
    win_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (winner[i]) begin
        win_value = win_value | req_value[VALUE_W*i +: VALUE_W];
        win_idx   = 3'(i);
      end
      if (grant_reg[i]) begin
        own_value = own_value | req_value[VALUE_W*i +: VALUE_W];
      end
    end
  end

  assign owner_req = |(req & grant_reg);
  assign at_dwell  = (cnt_reg == DWELL_MAX);

  // Next-state: grant on request, hold for the dwell, release on drop or expiry.
  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    ack_next   = '0;
    last_next  = last_reg;
    cnt_next   = cnt_reg;
    value_next = value_reg;
    blank_next = blank_reg;
    take       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (found) take = 1'b1;
      end
      SHOW: begin
        if (!owner_req) begin
          // A drop takes precedence over dwell expiry and ignores the dwell.
          if (found) begin
            take = 1'b1;
          end else begin
            state_next = IDLE;
            grant_next = '0;
            cnt_next   = '0;
            value_next = '0;
            blank_next = 1'b1;
          end
        end else if (at_dwell && found) begin
          take = 1'b1;
        end else begin
          if (!at_dwell) cnt_next = cnt_reg + 1'b1;
          value_next = own_value;
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
        cnt_next   = '0;
        value_next = '0;
        blank_next = 1'b1;
      end
    endcase
    if (take) begin
      state_next = SHOW;
      grant_next = winner;
      ack_next   = winner;
      last_next  = win_idx;
      cnt_next   = '0;
      value_next = win_value;
      blank_next = 1'b0;
    end
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      grant_reg <= '0;
      ack_reg   <= '0;
      last_reg  <= LAST_RST;
      cnt_reg   <= '0;
      value_reg <= '0;
      blank_reg <= 1'b1;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      ack_reg   <= ack_next;
      last_reg  <= last_next;
      cnt_reg   <= cnt_next;
      value_reg <= value_next;
      blank_reg <= blank_next;
    end
  end

  assign grant      = grant_reg;
  assign ack        = ack_reg;
  assign disp_value = value_reg;
  assign disp_blank = blank_reg;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Scoreboard bench for seg_display_arbiter with N_REQ=4 and an 8-cycle dwell.
module tb_seg_display_arbiter;

  localparam int N = 4;
  localparam int DW = 8;

  typedef struct packed {
    logic [3:0]  grant;
    logic [3:0]  ack;
    logic [15:0] value;
    logic        blank;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] vals [4];
  logic [63:0] req_value;
  logic [3:0]  ack, grant;
  logic [15:0] disp_value;
  logic        disp_blank;

  int total = 0;
  int bad = 0;
  int nstep = 0;

  exp_t sb[$];

  int m_owner, m_last, m_cnt;

  assign req_value = {vals[3], vals[2], vals[1], vals[0]};

  seg_display_arbiter #(.N_REQ(N), .DWELL_CYCLES(DW), .CNT_W(4)) dut (
    .clock_100Mhz (clk),
    .reset        (reset),
    .req          (req),
    .req_value    (req_value),
    .ack          (ack),
    .grant        (grant),
    .disp_value   (disp_value),
    .disp_blank   (disp_blank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    if (obs !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, obs, want);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = N - 1;
    m_cnt   = 0;
    sb.delete();
  endtask

  // Predict the next-edge outputs from the spec behaviour, then clock and compare.
  task automatic step();
    exp_t e;
    exp_t got;
    int   w;
    logic sw;
    w = -1;
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (m_last + k) % N;
      if (w < 0 && req[idx] && idx != m_owner) w = idx;
    end
    sw = 1'b0;
    if (m_owner < 0) begin
      if (w >= 0) sw = 1'b1;
    end else if (!req[m_owner]) begin
      if (w >= 0) sw = 1'b1;
      else begin
        m_owner = -1;
        m_cnt   = 0;
      end
    end else if (m_cnt == DW - 1 && w >= 0) begin
      sw = 1'b1;
    end else if (m_cnt < DW - 1) begin
      m_cnt++;
    end
    if (sw) begin
      m_owner = w;
      m_last  = w;
      m_cnt   = 0;
    end
    e.ack = sw ? 4'(1 << w) : 4'b0000;
    if (m_owner >= 0) begin
      e.grant = 4'(1 << m_owner);
      e.blank = 1'b0;
      e.value = vals[m_owner];
    end else begin
      e.grant = 4'b0000;
      e.blank = 1'b1;
      e.value = 16'd0;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    nstep++;
    $display("step %0d req=%b grant=%b ack=%b value=%0d blank=%b", nstep, req, grant, ack, disp_value, disp_blank);
    check("sb_grant", 32'(grant), 32'(got.grant));
    check("sb_ack", 32'(ack), 32'(got.ack));
    check("sb_value", 32'(disp_value), 32'(got.value));
    check("sb_blank", 32'(disp_blank), 32'(got.blank));
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int acks;
    logic [3:0] seqv [4];
    reset = 1'b0;
    req   = 4'b0000;
    vals[0] = 16'd11;
    vals[1] = 16'd22;
    vals[2] = 16'd33;
    vals[3] = 16'd44;
    model_reset();

    // Test 1: async reset mid-SHOW, then requester 0 wins from reset priority.
    do_reset();
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_blank", 32'(disp_blank), 32'h1);
    req = 4'b0010;
    repeat (3) step();
    #3;
    reset = 1'b1;
    #1;
    check("t1_async_grant", 32'(grant), 32'h0);
    check("t1_async_blank", 32'(disp_blank), 32'h1);
    check("t1_async_value", 32'(disp_value), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    req = 4'b1111;
    step();
    check("t1_first_grant", 32'(grant), 32'h1);

    // Test 2: single requester, live value update.
    do_reset();
    vals[2] = 16'd1234;
    req = 4'b0100;
    step();
    check("t2_grant", 32'(grant), 32'h4);
    check("t2_ack", 32'(ack), 32'h4);
    check("t2_value", 32'(disp_value), 32'd1234);
    step();
    check("t2_ack_gone", 32'(ack), 32'h0);
    vals[2] = 16'd1235;
    step();
    check("t2_live_value", 32'(disp_value), 32'd1235);

    // Test 3: rotation among 0,1,3 with exact 8-cycle dwell.
    do_reset();
    seqv[0] = 4'b0001;
    seqv[1] = 4'b0010;
    seqv[2] = 4'b1000;
    seqv[3] = 4'b0001;
    req = 4'b1011;
    acks = 0;
    for (int i = 0; i < 32; i++) begin
      step();
      check("t3_grant_seq", 32'(grant), 32'(seqv[i / 8]));
      if (ack != 4'b0000) acks++;
    end
    check("t3_ack_count", 32'(acks), 32'd4);

    // Test 4: voluntary drop at dwell_cnt=3 hands over immediately.
    do_reset();
    req = 4'b1010;
    step();
    check("t4_owner1", 32'(grant), 32'h2);
    repeat (3) step();
    req = 4'b1000;
    step();
    check("t4_grant", 32'(grant), 32'h8);
    check("t4_ack", 32'(ack), 32'h8);

    // Test 5: lone owner keeps the display past the dwell, then yields at once.
    do_reset();
    req = 4'b0001;
    acks = 0;
    repeat (20) begin
      step();
      if (ack != 4'b0000) acks++;
    end
    check("t5_single_ack", 32'(acks), 32'd1);
    check("t5_hold_grant", 32'(grant), 32'h1);
    req = 4'b0101;
    step();
    check("t5_switch_grant", 32'(grant), 32'h4);
    check("t5_switch_ack", 32'(ack), 32'h4);

    // Test 6: drop with nobody waiting, and a drop at dwell expiry.
    req = 4'b0000;
    step();
    check("t6_idle_grant", 32'(grant), 32'h0);
    check("t6_idle_blank", 32'(disp_blank), 32'h1);
    check("t6_idle_value", 32'(disp_value), 32'h0);
    req = 4'b0001;
    repeat (DW) step();
    req = 4'b0000;
    step();
    check("t6_exp_grant", 32'(grant), 32'h0);
    check("t6_exp_blank", 32'(disp_blank), 32'h1);
    check("t6_exp_value", 32'(disp_value), 32'h0);

    // Random traffic, including values above 9999 that must pass through untouched.
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) vals[$urandom_range(0, 3)] = 16'($urandom_range(0, 65535));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
